i2c_master_ctrl: RTL and testbench
==================================

// Module: i2c_master_ctrl
// PURPOSE
//  I2C bus initiator that drives single-byte transactions to the on-chip I2C slave memory subsystem.
//  Accepts a command on a valid/ready handshake and generates START, the 7-bit address plus R/W byte,
//  one data byte (write or read), the ACK/NACK bits and STOP.
//  Sits between the test/host logic and the open-drain SCL/SDA pins.
// PARAMETERS
//  CLK_DIV     4           clk cycles per SCL quarter-period; legal range >=1, elaborate-time $error otherwise
//  DEF_ADDR    7'b1001100  reset value of the internal last-address register; default matches the memory slave
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  cmd_valid  in   1  command request
//  cmd_ready  out  1  high when a command can be accepted (IDLE only)
//  cmd_rw     in   1  0 = write, 1 = read
//  cmd_addr   in   7  target slave address
//  cmd_wdata  in   8  byte to write; ignored for reads
//  busy       out  1  transaction in progress
//  done       out  1  one-cycle pulse when the transaction completes
//  ack_err    out  1  slave NACKed the address or write data; held until the next accept
//  rdata      out  8  byte received on a read; held until the next read completes
//  scl        out  1  SCL; master-only clock, no stretching supported
//  sda_oe     out  1  1 = pull SDA low; 0 = release (bus high by pull-up)
//  sda_in     in   1  sampled SDA line
// BEHAVIOUR
//  Reset values: scl=1, sda_oe=0, cmd_ready=1, busy=0, done=0, ack_err=0, rdata=8'h00, last-addr=DEF_ADDR.
//  Accept: the cycle with cmd_valid&&cmd_ready latches rw/addr/wdata, clears ack_err, and sets busy and
//   cmd_ready=0 on the next cycle. cmd_valid while busy is ignored; no queueing.
//  Bit period = 4 quarters (Q0..Q3), each CLK_DIV clk cycles, driven by a quarter counter plus a bit counter.
//   Q0: SCL low, SDA updated. Q1: SCL rises. Q2: SCL high, sda_in sampled on the last cycle of Q2.
//   Q3: SCL low.
//  FSM states, each lasting one bit period unless noted:
//   IDLE -> START on accept.
//   START: SDA released in Q0..Q1, sda_oe=1 in Q2 (falls while SCL high), SCL low in Q3.
//   ADDR: 8 bit periods, {addr,rw} MSB first.
//   AACK: SDA released; sample=1 -> ack_err=1, go to STOP; sample=0 -> WDATA (rw=0) or RDATA (rw=1).
//   WDATA: 8 bit periods, MSB first -> WACK. WACK: sample=1 sets ack_err; then STOP.
//   RDATA: SDA released; 8 samples shifted in MSB first -> RNACK.
//   RNACK: master releases SDA (NACK, single-byte read); rdata updated at the end of this period -> STOP.
//   STOP: sda_oe=1 in Q0..Q1, SCL high from Q1, sda_oe=0 in Q2 (rises while SCL high), Q3 SCL stays high.
//   Then done=1 for one cycle; busy=0 and cmd_ready=1 in that same cycle; return to IDLE.
//  SDA changes only while SCL is low, except the START and STOP edges.
//  Latency: full transaction = 20 bit periods = 80*CLK_DIV cycles. done asserts at cycle 80*CLK_DIV+1
//   after the accept cycle. An address-NACK transaction is 11 bit periods, done at 44*CLK_DIV+1.
//  Back-to-back: a command accepted in the done cycle starts START on the next cycle; SCL stays high in between.
//  Reset mid-transaction: next cycle forces IDLE, scl=1, sda_oe=0. The bus may see a spurious STOP; this is accepted.
//  ack_err and rdata are not modified by reset-free aborts, because none exist.
// TESTING
//  T1 write, CLK_DIV=4: addr=7'h4C, wdata=8'hA5, slave ACKs -> SDA bits 8'h98 then 8'hA5, ack_err=0, done at cycle 321.
//  T2 address NACK: addr=7'h11, slave releases SDA -> no data byte, STOP follows, ack_err=1, done at cycle 177.
//  T3 read: addr=7'h4C rw=1, slave model drives 8'h3C -> rdata=8'h3C, master SDA released at the 9th clock, ack_err=0.
//  T4 back-to-back: write then read accepted in the done cycle -> second START begins 1 cycle later, both complete correctly.
//  T5 busy: cmd_valid pulsed mid-transfer with different addr -> ignored, the original transaction bits are unchanged.
//  T6 reset at ADDR bit 3 -> next cycle scl=1, sda_oe=0, cmd_ready=1; a new write then completes normally.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C bus master: START, address+R/W, one data byte (write or read), ACK/NACK, STOP.
// SCL/SDA are registered and derived from the next bit-period position so both change cleanly on clk edges.
module i2c_master_ctrl #(
    parameter int         CLK_DIV  = 4,
    parameter logic [6:0] DEF_ADDR = 7'b1001100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in
);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("i2c_master_ctrl: CLK_DIV must be >= 1");
    end

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RNACK, STOP
    } state_t;

    state_t      state, nxt_state;
    logic [1:0]  quarter, nxt_quarter;
    logic [15:0] qcnt, nxt_qcnt;
    logic [2:0]  bitcnt, nxt_bitcnt;
    logic [7:0]  tx, nxt_tx;
    logic [7:0]  rx;
    logic [7:0]  wdata_q;
    logic [6:0]  last_addr;
    logic        rw_q;
    logic        sample;
    logic        accept;
    logic        last_cyc;
    logic        period_end;

    assign accept     = (state == IDLE) && cmd_valid && cmd_ready;
    assign last_cyc   = (qcnt == 16'(CLK_DIV - 1));
    assign period_end = (state != IDLE) && last_cyc && (quarter == 2'd3);

    // Bus levels for a given bit-period position; SCL is high in Q1..Q2 of ordinary bits.
    function automatic logic [1:0] line_drive(state_t st, logic [1:0] q, logic tx_bit);
        logic scl_hi;
        scl_hi = (q == 2'd1) || (q == 2'd2);
        case (st)
            START:                    line_drive = {q != 2'd3, q[1]};
            ADDR, WDATA:              line_drive = {scl_hi, ~tx_bit};
            AACK, WACK, RDATA, RNACK: line_drive = {scl_hi, 1'b0};
            STOP:                     line_drive = {q != 2'd0, ~q[1]};
            default:                  line_drive = 2'b10;
        endcase
    endfunction

    always_comb begin
        nxt_state   = state;
        nxt_quarter = quarter;
        nxt_qcnt    = qcnt;
        nxt_bitcnt  = bitcnt;
        nxt_tx      = tx;
        if (state == IDLE) begin
            if (accept) begin
                nxt_state   = START;
                nxt_quarter = 2'd0;
                nxt_qcnt    = 16'd0;
                nxt_bitcnt  = 3'd0;
            end
        end else begin
            nxt_qcnt = last_cyc ? 16'd0 : qcnt + 16'd1;
            if (last_cyc)
                nxt_quarter = quarter + 2'd1;
            if (period_end) begin
                nxt_bitcnt = bitcnt + 3'd1;
                nxt_tx     = {tx[6:0], 1'b0};
                case (state)
                    START: begin
                        nxt_state  = ADDR;
                        nxt_tx     = {last_addr, rw_q};
                        nxt_bitcnt = 3'd0;
                    end
                    ADDR:  if (bitcnt == 3'd7) nxt_state = AACK;
                    AACK: begin
                        nxt_bitcnt = 3'd0;
                        if (sample)
                            nxt_state = STOP;
                        else if (rw_q)
                            nxt_state = RDATA;
                        else begin
                            nxt_state = WDATA;
                            nxt_tx    = wdata_q;
                        end
                    end
                    WDATA: if (bitcnt == 3'd7) nxt_state = WACK;
                    WACK:  nxt_state = STOP;
                    RDATA: if (bitcnt == 3'd7) nxt_state = RNACK;
                    RNACK: nxt_state = STOP;
                    STOP:  nxt_state = IDLE;
                    default: nxt_state = IDLE;
                endcase
            end
        end
    end

    // Sequencer plus registered handshake, status and bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            quarter   <= 2'd0;
            qcnt      <= 16'd0;
            bitcnt    <= 3'd0;
            tx        <= 8'h00;
            rx        <= 8'h00;
            wdata_q   <= 8'h00;
            last_addr <= DEF_ADDR;
            rw_q      <= 1'b0;
            sample    <= 1'b0;
            scl       <= 1'b1;
            sda_oe    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
            rdata     <= 8'h00;
        end else begin
            state           <= nxt_state;
            quarter         <= nxt_quarter;
            qcnt            <= nxt_qcnt;
            bitcnt          <= nxt_bitcnt;
            tx              <= nxt_tx;
            {scl, sda_oe}   <= line_drive(nxt_state, nxt_quarter, nxt_tx[7]);
            done            <= 1'b0;
            if (accept) begin
                last_addr <= cmd_addr;
                rw_q      <= cmd_rw;
                wdata_q   <= cmd_wdata;
                ack_err   <= 1'b0;
                busy      <= 1'b1;
                cmd_ready <= 1'b0;
            end
            if (state != IDLE && last_cyc && quarter == 2'd2) begin
                sample <= sda_in;
                if (state == RDATA)
                    rx <= {rx[6:0], sda_in};
            end
            if (period_end) begin
                if ((state == AACK || state == WACK) && sample)
                    ack_err <= 1'b1;
                if (state == RNACK)
                    rdata <= rx;
                if (state == STOP) begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl with a behavioural memory-slave model on the SCL/SDA lines.
module tb_i2c_master_ctrl;

    localparam int         CLK_DIV    = 4;
    localparam logic [6:0] SLAVE_ADDR = 7'h4C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = 7'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       busy, done, ack_err, scl, sda_oe, sda_in;
    logic [7:0] rdata;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .DEF_ADDR(7'b1001100)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
        .scl(scl), .sda_oe(sda_oe), .sda_in(sda_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] data_byte;
        logic       full;
        logic       ack_err;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         done_edge = 0;
    logic [7:0] model_rdata = 8'h00;

    // Slave model state
    logic       pull = 1'b0;
    logic       sda_bus;
    logic       scl_q = 1'b1;
    logic       sda_q = 1'b1;
    int         rises = 0;
    logic [7:0] addr_cap = 8'h00;
    logic [7:0] data_cap = 8'h00;
    logic [7:0] rd_byte = 8'h00;
    logic       ninth_oe = 1'b1;
    logic       stop_seen = 1'b0;

    assign sda_bus = !((sda_oe === 1'b1) || pull);
    assign sda_in  = sda_bus;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Slave reacts to SCL edges and to SDA edges while SCL is high (START/STOP).
    always @(scl or sda_bus) begin
        if (scl === 1'b1 && scl_q === 1'b0) begin
            rises++;
            if (rises <= 8)
                addr_cap = {addr_cap[6:0], sda_bus};
            else if (rises >= 10 && rises <= 17)
                data_cap = {data_cap[6:0], sda_bus};
            else if (rises == 18)
                ninth_oe = sda_oe;
        end else if (scl === 1'b0 && scl_q === 1'b1) begin
            if (rises == 8)
                pull = (addr_cap[7:1] == SLAVE_ADDR);
            else if (rises == 9)
                pull = (addr_cap[7:1] == SLAVE_ADDR) && addr_cap[0] && !rd_byte[7];
            else if (rises >= 10 && rises <= 16)
                pull = addr_cap[0] && !rd_byte[16 - rises];
            else if (rises == 17)
                pull = !addr_cap[0];
            else
                pull = 1'b0;
        end else if (scl === 1'b1 && sda_bus === 1'b0 && sda_q === 1'b1) begin
            rises     = 0;
            stop_seen = 1'b0;
            ninth_oe  = 1'b1;
            data_cap  = 8'h00;
        end else if (scl === 1'b1 && sda_bus === 1'b1 && sda_q === 1'b0) begin
            stop_seen = 1'b1;
        end
        scl_q = scl;
        sda_q = sda_bus;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && cmd_valid && cmd_ready)
            acc_cyc <= cyc + 1;
    end

    // Pop and compare one expected transaction on every done pulse.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            exp_t e;
            done_edge = cyc;
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("addr_byte", addr_cap, e.addr_byte);
                checkOutput("scl_clocks", rises, e.full ? 19 : 10);
                if (e.full) begin
                    checkOutput("data_byte", data_cap, e.data_byte);
                    checkOutput("release_9th_clk", ninth_oe, 0);
                end
                checkOutput("ack_err", ack_err, e.ack_err);
                checkOutput("rdata", rdata, e.rdata);
                checkOutput("done_latency", cyc - acc_cyc + 1, e.lat);
                checkOutput("stop_seen", stop_seen, 1);
                checkOutput("busy_ready_done", {busy, cmd_ready}, 2'b01);
                checkOutput("bus_idle_done", {scl, sda_oe}, 2'b10);
            end
        end
    end

    task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] wdata, input bit expect_it);
        int   n = 0;
        exp_t e;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000)
            checkOutput("accept_timeout", 0, 1);
        @(posedge clk);
        if (expect_it) begin
            e.full = (addr == SLAVE_ADDR);
            if (rw && e.full)
                model_rdata = rd_byte;
            e.addr_byte = {addr, rw};
            e.data_byte = rw ? rd_byte : wdata;
            e.ack_err   = !e.full;
            e.rdata     = model_rdata;
            e.lat       = e.full ? 80 * CLK_DIV + 1 : 44 * CLK_DIV + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000)
            checkOutput("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_scl", scl, 1);
        checkOutput("rst_sda_oe", sda_oe, 0);
        checkOutput("rst_ready_busy_done", {cmd_ready, busy, done}, 3'b100);
        checkOutput("rst_ack_err", ack_err, 0);
        checkOutput("rst_rdata", rdata, 8'h00);
        rst = 1'b0;

        // Plain write, address NACK, read
        applyStimulus(1'b0, 7'h4C, 8'hA5, 1'b1);
        waitIdle();
        applyStimulus(1'b0, 7'h11, 8'h5A, 1'b1);
        waitIdle();
        rd_byte = 8'h3C;
        applyStimulus(1'b1, 7'h4C, 8'h00, 1'b1);
        waitIdle();

        // Back-to-back write then read, second accepted in the done cycle
        rd_byte = 8'h96;
        applyStimulus(1'b0, 7'h4C, 8'hC3, 1'b1);
        applyStimulus(1'b1, 7'h4C, 8'hFF, 1'b1);
        checkOutput("b2b_gap", acc_cyc - done_edge, 1);
        waitIdle();

        // Command pulsed while busy must be ignored
        applyStimulus(1'b0, 7'h4C, 8'h3E, 1'b1);
        repeat (100) @(negedge clk);
        cmd_addr  = 7'h11;
        cmd_wdata = 8'h00;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        waitIdle();

        // Reset in the middle of the address byte, then a clean write
        applyStimulus(1'b0, 7'h4C, 8'h77, 1'b0);
        repeat (70) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_scl", scl, 1);
        checkOutput("abort_sda_oe", sda_oe, 0);
        checkOutput("abort_ready_busy", {cmd_ready, busy}, 2'b10);
        checkOutput("abort_rdata", rdata, 8'h00);
        rst = 1'b0;
        model_rdata = 8'h00;
        applyStimulus(1'b0, 7'h4C, 8'h81, 1'b1);
        waitIdle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
